exec_unit: RTL and testbench

Multi-cycle execute stage sitting directly downstream of the 4x16 register file. It consumes the two read-data operands and produces a write-back triple (enable, register number, data). This triple connects straight to the register file write port. Single-cycle logic ops are combined with iterative 16-step multiply and divide, sequenced by a small FSM with start/busy handshake.

---
 rtl/exec_unit.sv | 178 +++++++++++++++++
 tb/tb_exec_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - multi-cycle execute stage: 1-cycle logic ops, iterative 16-step MUL/DIV
// Optional feature macro: EXEC_MOD_EN (opcode 110 = unsigned MOD)
module exec_unit #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [1:0]       dest_reg,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             wb_enable,
  output logic [1:0]       wb_reg_num,
  output logic [WIDTH-1:0] wb_data,
  output logic             zero_flag,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] reg_a;   // MUL: shifted multiplicand, DIV: dividend shifting into quotient
  logic [WIDTH-1:0] reg_b;   // MUL: shifted multiplier, DIV: divisor
  logic [WIDTH-1:0] acc;     // MUL: partial product, DIV: partial remainder
`ifdef EXEC_MOD_EN
  logic             is_mod;
`endif

  logic             alu_valid;
  logic [WIDTH-1:0] alu_result;
  logic             is_div_op;
  logic             is_mod_op;
  logic [WIDTH-1:0] dz_result;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] div_result;

  always_comb begin
    alu_valid  = 1'b1;
    alu_result = '0;
    case (opcode)
      3'b000:  alu_result = operand_a + operand_b;
      3'b001:  alu_result = operand_a - operand_b;
      3'b010:  alu_result = operand_a & operand_b;
      3'b011:  alu_result = operand_a | operand_b;
      default: alu_valid  = 1'b0;
    endcase
  end

  always_comb begin
`ifdef EXEC_MOD_EN
    is_mod_op = (opcode == 3'b110);
`else
    is_mod_op = 1'b0;
`endif
    is_div_op = (opcode == 3'b101) || is_mod_op;
    dz_result = is_mod_op ? operand_a : '1;
  end

  // Restoring division step: shift next dividend bit into remainder, subtract if it fits
  always_comb begin
    mul_acc_next = acc + (reg_b[0] ? reg_a : '0);
    rem_shift    = {acc, reg_a[WIDTH-1]};
    trial        = rem_shift - {1'b0, reg_b};
    rem_next     = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    quot_next    = {reg_a[WIDTH-2:0], ~trial[WIDTH]};
`ifdef EXEC_MOD_EN
    div_result   = is_mod ? rem_next : quot_next;
`else
    div_result   = quot_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      acc         <= '0;
`ifdef EXEC_MOD_EN
      is_mod      <= 1'b0;
`endif
      busy        <= 1'b0;
      wb_enable   <= 1'b0;
      wb_reg_num  <= '0;
      wb_data     <= '0;
      zero_flag   <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      wb_enable   <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wb_reg_num <= dest_reg;
            if (alu_valid) begin
              wb_data   <= alu_result;
              zero_flag <= (alu_result == '0);
              wb_enable <= 1'b1;
            end else if (opcode == 3'b100) begin
              state <= MUL;
              busy  <= 1'b1;
              reg_a <= operand_a;
              reg_b <= operand_b;
              acc   <= '0;
              count <= '0;
            end else if (is_div_op) begin
              if (operand_b == '0) begin
                wb_data     <= dz_result;
                zero_flag   <= (dz_result == '0);
                wb_enable   <= 1'b1;
                div_by_zero <= 1'b1;
              end else begin
                state  <= DIV;
                busy   <= 1'b1;
                reg_a  <= operand_a;
                reg_b  <= operand_b;
                acc    <= '0;
                count  <= '0;
`ifdef EXEC_MOD_EN
                is_mod <= is_mod_op;
`endif
              end
            end else begin
              illegal_op <= 1'b1;
            end
          end
        end
        MUL: begin
          acc   <= mul_acc_next;
          reg_a <= reg_a << 1;
          reg_b <= reg_b >> 1;
          count <= count + CW'(1);
          if (count == LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            count     <= '0;
            wb_data   <= mul_acc_next;
            zero_flag <= (mul_acc_next == '0);
            wb_enable <= 1'b1;
          end
        end
        DIV: begin
          acc   <= rem_next;
          reg_a <= quot_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            count     <= '0;
            wb_data   <= div_result;
            zero_flag <= (div_result == '0);
            wb_enable <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed self-checking bench for exec_unit
// Honours EXEC_MOD_EN when defined for the build.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  opcode;
  logic [1:0]  dest_reg;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        busy;
  logic        wb_enable;
  logic [1:0]  wb_reg_num;
  logic [15:0] wb_data;
  logic        zero_flag;
  logic        div_by_zero;
  logic        illegal_op;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int n;
  int pulses;

  exec_unit #(.WIDTH(16), .ITER(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .dest_reg    (dest_reg),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .wb_enable   (wb_enable),
    .wb_reg_num  (wb_reg_num),
    .wb_data     (wb_data),
    .zero_flag   (zero_flag),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accept edge, then scramble the operand inputs
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] d);
    start = 1'b1; opcode = op; operand_a = a; operand_b = b; dest_reg = d;
    step();
    start = 1'b0; operand_a = 16'hDEAD; operand_b = 16'hBEEF; opcode = 3'b000;
  endtask

  task automatic wait_wb(input int max, output int cycles);
    cycles = 0;
    while (!wb_enable && cycles < max) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 3'b000; dest_reg = 2'd0;
    operand_a = 16'h0; operand_b = 16'h0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_wb_enable", wb_enable, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_reg_num", wb_reg_num, 0);
    chk("rst_zero_flag", zero_flag, 0);
    chk("rst_flags", {div_by_zero, illegal_op}, 0);

    issue(3'b000, 16'h7FFF, 16'h0001, 2'd2);
    chk("add_wb_enable", wb_enable, 1);
    chk("add_wb_reg_num", wb_reg_num, 2);
    chk("add_wb_data", wb_data, 16'h8000);
    chk("add_zero_flag", zero_flag, 0);
    step();
    chk("add_wb_pulse_end", wb_enable, 0);
    chk("add_wb_data_held", wb_data, 16'h8000);

    issue(3'b001, 16'd5, 16'd5, 2'd3);
    chk("sub_wb_enable", wb_enable, 1);
    chk("sub_wb_data", wb_data, 0);
    chk("sub_zero_flag", zero_flag, 1);

    issue(3'b010, 16'hF0F0, 16'h3C3C, 2'd0);
    chk("and_wb_data", wb_data, 16'h3030);
    issue(3'b011, 16'hF0F0, 16'h0C0C, 2'd0);
    chk("or_wb_data", wb_data, 16'hFCFC);

    issue(3'b100, 16'h0123, 16'h0045, 2'd1);
    chk("mul_busy", busy, 1);
    chk("mul_no_early_wb", wb_enable, 0);
    wait_wb(40, n);
    chk("mul_latency", n, 16);
    chk("mul_wb_data", wb_data, 16'h4E6F);
    chk("mul_wb_reg_num", wb_reg_num, 1);
    chk("mul_busy_clear", busy, 0);
    chk("mul_zero_flag", zero_flag, 0);

    issue(3'b100, 16'h1234, 16'h0100, 2'd2);
    wait_wb(40, n);
    chk("mul_trunc_latency", n, 16);
    chk("mul_trunc_wb_data", wb_data, 16'h3400);

    issue(3'b101, 16'd1000, 16'd7, 2'd3);
    chk("div_busy", busy, 1);
    wait_wb(40, n);
    chk("div_latency", n, 16);
    chk("div_wb_data", wb_data, 16'h008E);
    chk("div_wb_reg_num", wb_reg_num, 3);

`ifdef EXEC_MOD_EN
    issue(3'b110, 16'd1000, 16'd7, 2'd1);
    chk("mod_busy", busy, 1);
    wait_wb(40, n);
    chk("mod_latency", n, 16);
    chk("mod_wb_data", wb_data, 16'h0006);
    issue(3'b110, 16'h1234, 16'h0000, 2'd1);
    chk("mod_dz_wb_data", wb_data, 16'h1234);
    chk("mod_dz_flag", div_by_zero, 1);
`else
    issue(3'b110, 16'd1000, 16'd7, 2'd1);
    chk("op110_illegal", illegal_op, 1);
    chk("op110_no_wb", wb_enable, 0);
    chk("op110_no_busy", busy, 0);
`endif

    issue(3'b111, 16'd1, 16'd2, 2'd0);
    chk("op111_illegal", illegal_op, 1);
    chk("op111_no_wb", wb_enable, 0);
    step();
    chk("op111_pulse_end", illegal_op, 0);

    issue(3'b101, 16'h1234, 16'h0000, 2'd2);
    chk("dz_wb_enable", wb_enable, 1);
    chk("dz_wb_data", wb_data, 16'hFFFF);
    chk("dz_flag", div_by_zero, 1);
    chk("dz_no_busy", busy, 0);
    step();
    chk("dz_pulse_end", {div_by_zero, wb_enable}, 0);

    issue(3'b100, 16'd3, 16'd5, 2'd0);
    step(); step(); step(); step();
    start = 1'b1; opcode = 3'b000; operand_a = 16'd100; operand_b = 16'd100; dest_reg = 2'd3;
    step();
    start = 1'b0;
    chk("ignored_add_no_wb", wb_enable, 0);
    chk("ignored_add_busy", busy, 1);
    pulses = 0;
    wait_wb(40, n);
    chk("ignored_add_latency", n, 11);
    chk("ignored_mul_wb_data", wb_data, 16'd15);
    chk("ignored_mul_wb_reg_num", wb_reg_num, 0);
    issue(3'b000, 16'd2, 16'd2, 2'd3);
    chk("b2b_wb_enable", wb_enable, 1);
    chk("b2b_wb_data", wb_data, 16'd4);
    chk("b2b_wb_reg_num", wb_reg_num, 3);

    issue(3'b101, 16'd1000, 16'd7, 2'd1);
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_wb_enable", wb_enable, 0);
    chk("abort_wb_data", wb_data, 0);
    chk("abort_outputs", {wb_reg_num, zero_flag, div_by_zero, illegal_op}, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (wb_enable) pulses++;
    end
    chk("abort_no_wb", pulses, 0);
    issue(3'b000, 16'd2, 16'd3, 2'd2);
    chk("post_abort_add", wb_data, 16'd5);
    chk("post_abort_wb_enable", wb_enable, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
